// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: multi-cycle multiply/divide engine owning the HI/LO registers.
//   Accepts MULTU / DIVU / MTHI / MTLO requests and holds the results for MFHI/MFLO.
//   Multiply is shift-add, LSB first; divide is restoring, MSB first; WIDTH iterations each.
//   Optional macro SIGNED_MULDIV_EN: op_signed=1 selects signed MULT/DIV. Operands are
//   taken as magnitudes when latched and the signs are applied when the result is written.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, op          request strobe (sampled in IDLE) and opcode (00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO)
//   op_signed          signed request (SIGNED_MULDIV_EN builds only)
//   src_a, src_b       operands; src_a is also the MTHI/MTLO write data
//   busy, done         op in flight / one-cycle completion pulse
//   div_by_zero        set with done for DIVU by zero, held until the next accepted start
//   hi, lo             architectural HI/LO registers
module hilo_muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIN,
        S_WR
    } state_t;

    state_t state, state_next;

    logic             accept;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [PW-1:0]    acc;       // product accumulator; low half holds the quotient when dividing
    logic [WIDTH:0]   rem;       // partial remainder
    logic             dz_q;
    logic             neg_pq;    // negate product / quotient at FIN
    logic             neg_r;     // negate remainder at FIN

    // Operand sign handling (only meaningful for MULT/DIV requests)
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;

`ifdef SIGNED_MULDIV_EN
    assign sign_a = op_signed & ~op[1] & src_a[WIDTH-1];
    assign sign_b = op_signed & ~op[1] & src_b[WIDTH-1];
`else
    logic unused_op_signed;
    assign unused_op_signed = op_signed;
    assign sign_a = 1'b0;
    assign sign_b = 1'b0;
`endif

    assign mag_a = sign_a ? (~src_a + WIDTH'(1)) : src_a;
    assign mag_b = sign_b ? (~src_b + WIDTH'(1)) : src_b;

    // Shift-add step: conditionally add multiplicand to upper half, then shift right with carry
    logic [WIDTH:0]  mul_sum;
    logic [PW-1:0]   mul_next;
    assign mul_sum  = {1'b0, acc[PW-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide step: shift in next dividend bit, keep the difference if it did not borrow
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_ok;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    assign div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, b_q};
    assign div_ok    = ~div_diff[WIDTH+1];
    assign rem_next  = div_ok ? div_diff[WIDTH:0] : div_shift;
    assign quo_next  = {acc[WIDTH-2:0], div_ok};

    // The partial remainder never reaches 2**WIDTH after a step, so its top bit is never read
    logic unused_rem_msb;
    assign unused_rem_msb = rem[WIDTH];

    // Sign fix-ups applied when the result is written
    logic [PW-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    assign prod_fix = neg_pq ? (~acc + PW'(1)) : acc;
    assign quo_fix  = neg_pq ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
    assign rem_fix  = neg_r ? (~rem[WIDTH-1:0] + WIDTH'(1)) : rem[WIDTH-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the done cycle still belongs to the finishing op, so start is held off
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !done) begin
                    accept = 1'b1;
                    case (op)
                        OP_MULTU: state_next = S_MUL;
                        OP_DIVU:  state_next = (src_b == '0) ? S_FIN : S_DIV;
                        default:  state_next = S_WR;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                if (cnt == CNT_LAST) begin
                    state_next = S_FIN;
                end
            end
            S_FIN, S_WR: state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc         <= '0;
            rem         <= '0;
            dz_q        <= 1'b0;
            neg_pq      <= 1'b0;
            neg_r       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q        <= op;
                        a_q         <= mag_a;
                        b_q         <= mag_b;
                        cnt         <= '0;
                        rem         <= '0;
                        busy        <= ~op[1];
                        div_by_zero <= 1'b0;
                        dz_q        <= (op == OP_DIVU) && (src_b == '0);
                        neg_pq      <= sign_a ^ sign_b;
                        neg_r       <= sign_a;
                        acc         <= {{WIDTH{1'b0}}, (op[0] ? mag_a : mag_b)};
                    end
                end
                S_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + CNT_W'(1);
                end
                S_DIV: begin
                    acc[WIDTH-1:0] <= quo_next;
                    rem            <= rem_next;
                    cnt            <= cnt + CNT_W'(1);
                end
                S_FIN: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (dz_q) begin
                        hi          <= '0;
                        lo          <= '0;
                        div_by_zero <= 1'b1;
                    end else if (op_q == OP_MULTU) begin
                        hi <= prod_fix[PW-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                S_WR: begin
                    done <= 1'b1;
                    if (op_q == OP_MTHI) begin
                        hi <= a_q;
                    end else begin
                        lo <= a_q;
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
